// File: rtl/cxl_mem_arbiter.sv
// Weighted round-robin arbiter sharing one CXL.mem request/response channel
// between several requesters, with in-order response routing via a tag FIFO.
module cxl_mem_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned WEIGHT_WIDTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]      cfg_weight,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    output logic [NUM_REQ-1:0]                   resp_valid,
    input  logic [NUM_REQ-1:0]                   resp_ready,
    output logic [DATA_WIDTH-1:0]                resp_data,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic                                 mem_req_write,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    output logic [DATA_WIDTH-1:0]                mem_req_data,
    input  logic                                 mem_resp_valid,
    output logic                                 mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]                mem_resp_data,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_cnt,
    output logic [31:0]                          orphan_resp_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BW    = WEIGHT_WIDTH + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] last_grant;
    logic [BW-1:0]    burst_cnt;
    logic [IDX_W-1:0] grant;
    logic             grant_found;
    logic             can_accept;
    logic             accept;
    logic [BW-1:0]    burst_next;
    logic [BW-1:0]    weight_eff;

    logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             orphan;

    // Rotational search for the first valid requester starting at rr_ptr
    always_comb begin : grant_search
        int unsigned idx;
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + 32'(k);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[IDX_W'(idx)]) begin
                grant_found = 1'b1;
                grant       = IDX_W'(idx);
            end
        end
    end

    // Full flag derives from the registered count, so a same-cycle pop cannot unblock
    assign fifo_full  = (outstanding_cnt == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (outstanding_cnt == '0);
    assign can_accept = (!mem_req_valid || mem_req_ready) && !fifo_full;
    assign accept     = rst_n && grant_found && can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    always_comb begin
        weight_eff = BW'(cfg_weight[32'(grant)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        if (weight_eff == '0) weight_eff = BW'(1);
        burst_next = (grant == last_grant) ? burst_cnt + BW'(1) : BW'(1);
    end

    // Response routing to the requester at the FIFO head; orphans are always drained
    assign head      = tag_mem[rd_ptr];
    assign resp_data = mem_resp_data;

    always_comb begin
        resp_valid     = '0;
        mem_resp_ready = 1'b0;
        if (rst_n) begin
            if (fifo_empty) begin
                mem_resp_ready = 1'b1;
            end else begin
                mem_resp_ready   = resp_ready[head];
                resp_valid[head] = mem_resp_valid;
            end
        end
    end

    assign pop    = mem_resp_valid && mem_resp_ready && !fifo_empty;
    assign orphan = rst_n && mem_resp_valid && fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_valid     <= 1'b0;
            mem_req_write     <= 1'b0;
            mem_req_addr      <= '0;
            mem_req_data      <= '0;
            outstanding_cnt   <= '0;
            orphan_resp_count <= '0;
            rr_ptr            <= '0;
            last_grant        <= '0;
            burst_cnt         <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
        end else begin
            if (accept) begin
                mem_req_valid <= 1'b1;
                mem_req_write <= req_write[grant];
                mem_req_addr  <= req_addr[32'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_req_data  <= req_data[32'(grant)*DATA_WIDTH +: DATA_WIDTH];
                wr_ptr        <= wr_ptr + PTR_W'(1);
                last_grant    <= grant;
                if (burst_next >= weight_eff) begin
                    rr_ptr    <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + IDX_W'(1);
                    burst_cnt <= '0;
                end else begin
                    rr_ptr    <= grant;
                    burst_cnt <= burst_next;
                end
            end else if (mem_req_ready) begin
                mem_req_valid <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
                2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
                default: outstanding_cnt <= outstanding_cnt;
            endcase
            if (orphan && (orphan_resp_count != '1))
                orphan_resp_count <= orphan_resp_count + 32'd1;
        end
    end

    // Tag storage needs no reset; only entries between the pointers are read
    always_ff @(posedge clk) begin
        if (accept) tag_mem[wr_ptr] <= grant;
    end

endmodule
